// File: rtl/audio_pkg.sv
// Shared types for the audio output path.
// Sample width and DAC serializer state encoding.
package audio_pkg;

  localparam int AUDIO_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SLOT,
    SHIFT,
    PAD
  } dac_state_e;

endpackage

// File: rtl/sync_edge.sv
// Single-bit synchroniser followed by an edge detector.
// Level, rise and fall are all aligned to the final sync stage.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/i2s_dac_serializer.sv
// Mono sample stream to WM8731 I2S DAC (codec is bus master).
// One pending-sample buffer; same word sent on left and right slots.
module i2s_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W      = AUDIO_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enable,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_bclk,
  input  logic                     i_lrc,
  output logic                     o_dacdat,
  output logic                     o_underrun,
  output logic                     o_overrun
);

  localparam int CNT_W  = $clog2(DATA_W);
  localparam int CNT_W1 = CNT_W + 1;

  logic w_bclk_lvl;
  logic w_bclk_rise;
  logic w_bclk_fall;
  logic w_lrc_lvl;
  logic w_lrc_rise;
  logic w_lrc_fall;
  logic w_lrc_edge;
  logic w_unused;

  dac_state_e r_state;
  dac_state_e w_state_nxt;
  logic [CNT_W1-1:0] r_bit_cnt;
  logic [CNT_W1-1:0] w_cnt_nxt;
  logic r_dacdat;
  logic w_dac_nxt;

  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_pend_data;
  logic r_pending;
  logic r_under;
  logic r_over;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_bclk),
    .o_level(w_bclk_lvl),
    .o_rise (w_bclk_rise),
    .o_fall (w_bclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrc_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_lrc),
    .o_level(w_lrc_lvl),
    .o_rise (w_lrc_rise),
    .o_fall (w_lrc_fall)
  );

  assign w_lrc_edge = w_lrc_rise | w_lrc_fall;
  assign w_unused   = ^{w_bclk_lvl, w_bclk_rise, w_lrc_lvl};

  // Sample buffer: a same-cycle strobe replaces a word being consumed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word      <= '0;
      r_pend_data <= '0;
      r_pending   <= 1'b0;
      r_under     <= 1'b0;
      r_over      <= 1'b0;
    end else if (!i_enable) begin
      r_pending <= 1'b0;
      r_under   <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_under <= w_lrc_fall & ~r_pending;
      r_over  <= i_valid & r_pending & ~w_lrc_fall;
      if (w_lrc_fall && r_pending) begin
        r_word    <= r_pend_data;
        r_pending <= 1'b0;
      end
      if (i_valid) begin
        r_pend_data <= i_data;
        r_pending   <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_dacdat  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_dacdat  <= w_dac_nxt;
    end
  end

  // Counter MSB set means bit 0 has already been driven
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_dac_nxt   = r_dacdat;
    if (!i_enable) begin
      w_state_nxt = IDLE;
      w_dac_nxt   = 1'b0;
    end else if (r_state == IDLE) begin
      w_dac_nxt = 1'b0;
      if (w_lrc_fall) w_state_nxt = WAIT_SLOT;
    end else if (w_lrc_edge) begin
      w_state_nxt = WAIT_SLOT;
    end else if (w_bclk_fall) begin
      unique case (r_state)
        WAIT_SLOT: begin
          w_dac_nxt   = r_word[DATA_W-1];
          w_cnt_nxt   = CNT_W1'(DATA_W - 2);
          w_state_nxt = SHIFT;
        end
        SHIFT: begin
          if (r_bit_cnt[CNT_W]) begin
            w_dac_nxt   = 1'b0;
            w_state_nxt = PAD;
          end else begin
            w_dac_nxt = r_word[r_bit_cnt[CNT_W-1:0]];
            w_cnt_nxt = r_bit_cnt - CNT_W1'(1);
          end
        end
        PAD: w_dac_nxt = 1'b0;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign o_dacdat   = r_dacdat;
  assign o_underrun = r_under;
  assign o_overrun  = r_over;

endmodule

// File: doc/i2s_dac_serializer.md
Name: i2s_dac_serializer

Overview:
- Final output stage of the effects chain; consumes the 16-bit signed sample stream (`data`/`valid`) produced by the last effect stage, e.g. tremolo.
- Serialises the stream to the WM8731 DAC in I2S format. The codec is bus master and drives BCLK and DACLRCK.
- Mono source: the same sample word is sent on the left and right slots.
- Single-entry buffer between the system-clock sample stream and the codec frame timing, with underrun and overrun flags.

Parameters:
- DATA_W, 16, sample width and bits shifted per slot
- SYNC_STAGES, 2, flip-flop depth of the BCLK/LRC synchronisers (minimum 2)

Ports:
- i_clk  in  1  system clock, rising-edge
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  output enable; low forces silence
- i_valid  in  1  one-cycle strobe, i_data holds a new sample
- i_data  in  DATA_W  signed sample from the upstream effect
- i_bclk  in  1  codec bit clock, asynchronous to i_clk
- i_lrc  in  1  codec DACLRCK, low = left, high = right
- o_dacdat  out  1  serial data to codec, registered
- o_underrun  out  1  one-cycle pulse: left frame started with no pending sample
- o_overrun  out  1  one-cycle pulse: pending sample overwritten before being consumed

Behaviour:
- Reset:
  - All outputs 0.
  - pending_r=0, pend_data_r=0, word_r=0, bit_cnt=0, state IDLE.
  - Synchroniser flops are cleared to 0.
- Clock domain:
  - Everything runs on i_clk.
  - i_bclk and i_lrc each pass through SYNC_STAGES flops, then one extra flop for edge detection.
  - bclk_fall = prev 1 and now 0; lrc_fall and lrc_rise are defined the same way.
  - BCLK high and low phases are each ≥ 3 i_clk cycles.
- Buffer:
  - When i_valid and i_enable: pend_data_r <= i_data and pending_r <= 1.
  - If pending_r is already 1 and is not being consumed in that cycle, o_overrun pulses.
- Consume:
  - On lrc_fall (left frame start) with pending_r=1: word_r <= pend_data_r and pending_r <= 0.
  - If i_valid occurs in the same cycle, the old pend_data_r is consumed, the new sample becomes pending, and there is no overrun.
  - On lrc_fall with pending_r=0: word_r holds its last value and o_underrun pulses.
  - On lrc_rise (right slot): word_r is unchanged.
- FSM states: IDLE, WAIT_SLOT, SHIFT, PAD.
  - IDLE: o_dacdat=0. Go to WAIT_SLOT on lrc_fall only, so channel alignment always starts at left.
  - WAIT_SLOT: this is the I2S one-BCLK delay. On bclk_fall: o_dacdat <= word_r[DATA_W-1], bit_cnt <= DATA_W-2, go to SHIFT.
  - SHIFT: on each bclk_fall, o_dacdat <= word_r[bit_cnt] and bit_cnt decrements. On the bclk_fall after bit 0 has been driven, o_dacdat <= 0 and go to PAD.
  - PAD: o_dacdat=0 until the next LRC edge.
- Any LRC edge in WAIT_SLOT, SHIFT or PAD:
  - Go to WAIT_SLOT and restart the slot.
  - A short frame aborts the shift in progress; the new slot starts again at the MSB.
  - LRC edge and bclk_fall in the same cycle: the LRC edge wins and state becomes WAIT_SLOT.
- Disable:
  - When i_enable=0: o_dacdat <= 0 on the next clock, pending_r <= 0, state IDLE.
  - No flags are raised while disabled.
  - After re-enable, output resumes at the next lrc_fall.
- Latency:
  - A sample is emitted in the first left frame after its strobe.
  - The MSB appears one BCLK after the LRC falling edge, plus synchroniser delay (SYNC_STAGES+1 i_clk cycles, plus 1 for the output register).
- Arithmetic: no arithmetic on sample data. Bits go out MSB first, two's complement, unmodified.

Decomposition:
- audio_pkg holds:
  - AUDIO_W=16
  - state enum dac_state_e {IDLE, WAIT_SLOT, SHIFT, PAD}
- One sub-module, sync_edge (parameter SYNC_STAGES):
  - 1-bit synchroniser plus edge detector.
  - Outputs: level, rise, fall.
  - Instantiated twice, for i_bclk and i_lrc.

Test Plan:
- Reset asserted mid-frame -> o_dacdat, o_underrun, o_overrun go 0 immediately; after release, nothing is shifted until an lrc_fall.
- Strobe 16'hA5C3, then LRC falls (BCLK = 20 i_clk period) -> left slot after one BCLK delay: 1010_0101_1100_0011, then zeros. The right slot repeats the same bits.
- No strobe before the next left frame -> o_underrun pulses exactly 1 cycle and 16'hA5C3 is re-sent.
- Strobe 16'h1111, then 16'h2222, both before the frame -> o_overrun pulses 1 cycle on the second strobe; the frame carries 16'h2222.
- Pending 16'h3333, then strobe 16'h4444 in the same cycle as lrc_fall is detected -> this frame sends 3333, the next left frame sends 4444, and there is no overrun or underrun.
- Short frame and disable:
  - LRC toggles after 8 BCLKs -> the shift aborts and the new slot restarts at the MSB.
  - i_enable drops mid-slot -> o_dacdat is 0 within 1 cycle; after re-enable, output resumes on the next lrc_fall only.
